// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder with streaming program load
module imem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [31:0]           mem_req_addr,
    input  logic                  mem_req_stb,
    output logic [31:0]           mem_req_data,
    output logic                  mem_req_valid,
    input  logic                  ld_en,
    input  logic [31:0]           ld_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    output logic                  ld_done,
    output logic [DEPTH_LOG2:0]   ld_count,
    output logic                  oob_err
);
    localparam int unsigned         DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LAST  = (DEPTH_LOG2 + 1)'(DEPTH - 1);
    localparam logic [DEPTH_LOG2:0] ONE   = (DEPTH_LOG2 + 1)'(1);

    typedef enum logic {SERVE, LOAD} state_t;

    state_t                     state_q, state_d;
    logic [DEPTH_LOG2:0]        ld_count_q, ld_count_d;
    logic                       ld_done_q, ld_done_d;
    logic                       oob_q, oob_d;
    logic                       block_q, block_d;
    logic [LATENCY-1:0]         vld_q, vld_d;
    logic [LATENCY-1:0][31:0]   dat_q, dat_d;

    logic [31:0]                mem [DEPTH];

    logic [31:0]                offset;
    logic [DEPTH_LOG2-1:0]      req_idx;
    logic                       req_bad;
    logic                       load_start;
    logic                       accept;
    logic                       ld_wr;
    logic                       full_exit;

    always_comb begin
        offset  = mem_req_addr - BASE_ADDR;
        req_idx = offset[DEPTH_LOG2+1:2];
        req_bad = (mem_req_addr < BASE_ADDR) ||
                  ((offset >> (DEPTH_LOG2 + 2)) != 32'd0) ||
                  (mem_req_addr[1:0] != 2'b00);
    end

    // block_q keeps a still-held ld_en from restarting a load after the array filled
    assign ld_ready   = (state_q == LOAD) && (ld_count_q < FULL);
    assign load_start = (state_q == SERVE) && ld_en && !block_q;
    assign accept     = (state_q == SERVE) && mem_req_stb && !load_start;
    assign ld_wr      = ld_ready && ld_valid;
    assign full_exit  = ld_wr && (ld_count_q == LAST);

    always_comb begin
        state_d    = state_q;
        ld_count_d = ld_count_q;
        ld_done_d  = 1'b0;
        oob_d      = oob_q;
        block_d    = block_q;
        case (state_q)
            SERVE: begin
                if (load_start) begin
                    state_d    = LOAD;
                    ld_count_d = '0;
                end
                if (!ld_en) begin
                    block_d = 1'b0;
                end
                if (accept && req_bad) begin
                    oob_d = 1'b1;
                end
            end
            LOAD: begin
                if (ld_wr) begin
                    ld_count_d = ld_count_q + ONE;
                end
                if (full_exit || !ld_en) begin
                    state_d   = SERVE;
                    ld_done_d = 1'b1;
                    block_d   = full_exit && ld_en;
                end
            end
            default: state_d = SERVE;
        endcase
    end

    // Data stages only advance behind a valid bit, so the output word holds across bubbles
    always_comb begin
        vld_d    = '0;
        dat_d    = dat_q;
        vld_d[0] = accept;
        if (accept) begin
            dat_d[0] = req_bad ? 32'h0 : mem[req_idx];
        end
        for (int k = 1; k < LATENCY; k++) begin
            vld_d[k] = vld_q[k-1] && !load_start;
            if (vld_q[k-1] && !load_start) begin
                dat_d[k] = dat_q[k-1];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= SERVE;
            ld_count_q <= '0;
            ld_done_q  <= 1'b0;
            oob_q      <= 1'b0;
            block_q    <= 1'b0;
            vld_q      <= '0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            ld_count_q <= ld_count_d;
            ld_done_q  <= ld_done_d;
            oob_q      <= oob_d;
            block_q    <= block_d;
            vld_q      <= vld_d;
            dat_q      <= dat_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (ld_wr) begin
            mem[ld_count_q[DEPTH_LOG2-1:0]] <= ld_data;
        end
    end

    assign mem_req_valid = vld_q[LATENCY-1];
    assign mem_req_data  = dat_q[LATENCY-1];
    assign ld_done       = ld_done_q;
    assign ld_count      = ld_count_q;
    assign oob_err       = oob_q;
endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - bench for imem_responder: directed tables plus randomized model check
module tb_imem_responder;
    localparam int unsigned DL    = 3;
    localparam int unsigned LAT   = 3;
    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_req_addr;
    logic        mem_req_stb;
    logic [31:0] mem_req_data;
    logic        mem_req_valid;
    logic        ld_en;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        ld_ready;
    logic        ld_done;
    logic [DL:0] ld_count;
    logic        oob_err;

    imem_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
        .i_clk(clk), .i_reset(rst),
        .mem_req_addr(mem_req_addr), .mem_req_stb(mem_req_stb),
        .mem_req_data(mem_req_data), .mem_req_valid(mem_req_valid),
        .ld_en(ld_en), .ld_data(ld_data), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_done(ld_done), .ld_count(ld_count), .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int done_seen = 0;

    // Reference model: word array, load progress and a time-indexed response schedule
    bit [31:0] mmem [DEPTH];
    bit        m_load, m_blk, m_done, m_oob;
    int        m_cnt;
    bit [31:0] m_last;
    bit        exp_v [8];
    bit [31:0] exp_d [8];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        oob;
    } rd_vec_t;
    rd_vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_load = 0; m_blk = 0; m_done = 0; m_oob = 0; m_cnt = 0; m_last = 0;
        for (int i = 0; i < 8; i++) exp_v[i] = 0;
    endtask

    task automatic model_edge();
        logic [31:0] off;
        bit          bad;
        m_done = 0;
        if (!m_load) begin
            if (ld_en && !m_blk) begin
                m_load = 1;
                m_cnt  = 0;
                for (int i = 0; i < 8; i++) exp_v[i] = 0;
            end else begin
                if (mem_req_stb) begin
                    off = mem_req_addr - BASE;
                    bad = (mem_req_addr < BASE) || ((off >> 2) >= DEPTH) || (mem_req_addr % 4 != 0);
                    exp_v[(cyc + LAT) % 8] = 1;
                    exp_d[(cyc + LAT) % 8] = bad ? 32'h0 : mmem[off >> 2];
                    if (bad) m_oob = 1;
                end
                if (!ld_en) m_blk = 0;
            end
        end else begin
            if (ld_valid && m_cnt < DEPTH) begin
                mmem[m_cnt] = ld_data;
                m_cnt++;
            end
            if (m_cnt == DEPTH) begin
                m_load = 0; m_done = 1; m_blk = ld_en;
            end else if (!ld_en) begin
                m_load = 0; m_done = 1;
            end
        end
    endtask

    task automatic compare();
        int s;
        bit ev;
        s  = cyc % 8;
        ev = exp_v[s];
        if (ev) m_last = exp_d[s];
        exp_v[s] = 0;
        chk("mem_req_valid", 32'(mem_req_valid), 32'(ev));
        chk("mem_req_data", mem_req_data, m_last);
        chk("ld_ready", 32'(ld_ready), 32'(m_load && (m_cnt < DEPTH)));
        chk("ld_done", 32'(ld_done), 32'(m_done));
        chk("ld_count", 32'(ld_count), 32'(m_cnt));
        chk("oob_err", 32'(oob_err), 32'(m_oob));
        if (ld_done) done_seen++;
    endtask

    task automatic step();
        if (ld_ready && ld_valid) acc_cnt++;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        compare();
    endtask

    task automatic read_chk(input string nm, input logic [31:0] addr,
                            input logic [31:0] data, input logic oob);
        mem_req_addr = addr;
        mem_req_stb  = 1;
        step();
        mem_req_stb = 0;
        repeat (LAT - 1) step();
        chk({nm, " valid"}, 32'(mem_req_valid), 32'h1);
        chk({nm, " data"}, mem_req_data, data);
        chk({nm, " oob"}, 32'(oob_err), 32'(oob));
    endtask

    task automatic async_reset_chk(input string nm);
        #2;
        rst = 1;
        #1;
        model_reset();
        chk({nm, " rst valid"}, 32'(mem_req_valid), 32'h0);
        chk({nm, " rst data"}, mem_req_data, 32'h0);
        chk({nm, " rst ready"}, 32'(ld_ready), 32'h0);
        chk({nm, " rst done"}, 32'(ld_done), 32'h0);
        chk({nm, " rst count"}, 32'(ld_count), 32'h0);
        chk({nm, " rst oob"}, 32'(oob_err), 32'h0);
        ld_en = 0; ld_valid = 0; mem_req_stb = 0;
        #1;
        rst = 0;
    endtask

    initial begin
        int          vcnt;
        int          d0;
        bit          pv [6];
        logic [31:0] pd [6];
        bit          pstb [6];
        logic [31:0] paddr [6];

        tbl[0] = '{32'h100, 32'h11, 1'b0};
        tbl[1] = '{32'h104, 32'h22, 1'b0};
        tbl[2] = '{32'h10C, 32'h44, 1'b0};
        tbl[3] = '{32'h110, 32'hC0DE0004, 1'b0};
        tbl[4] = '{32'h11C, 32'hC0DE0007, 1'b0};
        tbl[5] = '{32'h0FC, 32'h0, 1'b1};
        tbl[6] = '{32'h102, 32'h0, 1'b1};
        tbl[7] = '{32'h120, 32'h0, 1'b1};
        tbl[8] = '{32'h000, 32'h0, 1'b1};
        tbl[9] = '{32'hFFFFFFFC, 32'h0, 1'b1};

        rst = 1; mem_req_addr = 0; mem_req_stb = 0; ld_en = 0; ld_data = 0; ld_valid = 0;
        model_reset();
        #12;
        chk("reset valid", 32'(mem_req_valid), 32'h0);
        chk("reset data", mem_req_data, 32'h0);
        chk("reset ready", 32'(ld_ready), 32'h0);
        chk("reset count", 32'(ld_count), 32'h0);
        chk("reset oob", 32'(oob_err), 32'h0);
        #1;
        rst = 0;

        // Full array: 10 beats offered with ld_en held, only DEPTH accepted
        ld_en = 1;
        step();
        chk("load ready rises", 32'(ld_ready), 32'h1);
        acc_cnt = 0; done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            ld_valid = 1;
            ld_data  = 32'hC0DE0000 + 32'(i);
            step();
        end
        ld_valid = 0;
        step();
        chk("full accepted", 32'(acc_cnt), 32'd8);
        chk("full count", 32'(ld_count), 32'd8);
        chk("full done pulses", 32'(done_seen), 32'd1);
        chk("full ready low", 32'(ld_ready), 32'h0);
        read_chk("serve while held", 32'h11C, 32'hC0DE0007, 1'b0);
        ld_en = 0;
        step();

        // Partial load of four words, ended by dropping ld_en
        ld_en = 1;
        step();
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1;
            ld_data  = 32'h11 * 32'(i + 1);
            step();
        end
        ld_valid = 0; ld_en = 0;
        step();
        chk("load4 done", 32'(ld_done), 32'h1);
        chk("load4 count", 32'(ld_count), 32'd4);
        step();
        chk("load4 done once", 32'(done_seen), 32'd1);

        for (int i = 0; i < 10; i++) begin
            read_chk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].data, tbl[i].oob);
        end

        // Bubble pattern 1,0,1
        pstb  = '{1, 0, 1, 0, 0, 0};
        paddr = '{32'h100, 32'h104, 32'h108, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            mem_req_stb  = pstb[i];
            mem_req_addr = paddr[i];
            step();
            pv[i] = mem_req_valid;
            pd[i] = mem_req_data;
        end
        mem_req_stb = 0;
        chk("bubble v0", 32'(pv[LAT-1]), 32'h1);
        chk("bubble v1", 32'(pv[LAT]), 32'h0);
        chk("bubble v2", 32'(pv[LAT+1]), 32'h1);
        chk("bubble v3", 32'(pv[LAT+2]), 32'h0);
        chk("bubble d0", pd[LAT-1], 32'h11);
        chk("bubble hold", pd[LAT], 32'h11);
        chk("bubble d2", pd[LAT+1], 32'h33);

        // In-flight request dropped by a load start; request in the ld_en cycle dropped too
        mem_req_addr = 32'h100; mem_req_stb = 1;
        step();
        mem_req_addr = 32'h104; ld_en = 1;
        chk("flush ready before", 32'(ld_ready), 32'h0);
        step();
        chk("flush ready after", 32'(ld_ready), 32'h1);
        mem_req_stb = 0;
        vcnt = (mem_req_valid) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            step();
            vcnt += (mem_req_valid) ? 1 : 0;
        end
        ld_en = 0;
        step();
        chk("flush done", 32'(ld_done), 32'h1);
        chk("flush count", 32'(ld_count), 32'h0);
        for (int i = 0; i < LAT; i++) begin
            step();
            vcnt += (mem_req_valid) ? 1 : 0;
        end
        chk("flush no valid", 32'(vcnt), 32'h0);

        // Reset in the middle of a load
        ld_en = 1;
        step();
        ld_valid = 1; ld_data = 32'hA0;
        step();
        ld_data = 32'hA1;
        step();
        ld_valid = 0;
        chk("midload count", 32'(ld_count), 32'd2);
        async_reset_chk("midload");
        d0 = done_seen;
        repeat (3) step();
        chk("midload no done", 32'(done_seen - d0), 32'h0);
        read_chk("midload w0", 32'h100, 32'hA0, 1'b0);
        read_chk("midload w1", 32'h104, 32'hA1, 1'b0);
        read_chk("midload w2", 32'h108, 32'h33, 1'b0);
        read_chk("midload w3", 32'h10C, 32'h44, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (!ld_en) ld_en = ($urandom_range(0, 24) == 0);
            else        ld_en = ($urandom_range(0, 9) != 0);
            ld_valid    = $urandom_range(0, 1) == 1;
            ld_data     = $urandom;
            mem_req_stb = $urandom_range(0, 3) != 0;
            case ($urandom_range(0, 9))
                0:       mem_req_addr = BASE - 32'd4;
                1:       mem_req_addr = BASE + 32'(DEPTH * 4);
                2:       mem_req_addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'd2;
                3:       mem_req_addr = $urandom;
                default: mem_req_addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            endcase
            step();
            if (i == 300) async_reset_chk("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
